bcd_updown_counter: RTL and testbench
=====================================

# bcd_updown_counter

Parametrised N-digit BCD counter. Counts up or down, with a synchronous parallel load that validates each digit, and a selectable wrap or saturate mode at the range limits. It generalises the team's fixed three-digit up-only BCD counter and sits behind the Tiny Tapeout top-level wrapper as a reusable datapath block for display/timer projects.

## Interface
Parameters:
- DIGITS, default 3: number of BCD digits. Legal range 1..8. Counter range is 0 .. 10^DIGITS−1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; synchronous, active-low.
- en  in  1  count enable; one step per clock while high.
- up  in  1  direction: 1 = increment, 0 = decrement.
- sat  in  1  limit mode: 0 = wrap, 1 = saturate.
- load  in  1  parallel load request.
- load_val  in  4*DIGITS  load value; digit i in bits [4i+3:4i], digit 0 = units.
- count  out  4*DIGITS  registered BCD count; same digit packing as load_val.
- wrap  out  1  registered one-cycle pulse; high in the cycle after a wrap step.
- load_err  out  1  registered one-cycle pulse; high in the cycle after a rejected load.
- is_zero  out  1  combinational; high when count == all zeros.
- is_max  out  1  combinational; high when every digit == 9.

## Operation
Priority, evaluated at each rising clk edge:
1. Reset.
2. Load.
3. Count.
4. Hold.

- **Reset** (rst_n=0 at edge): count=0, wrap=0, load_err=0. This gives is_zero=1 and is_max=0. Reset overrides load and en.
- **Load** (load=1):
  - If every nibble of load_val is ≤9: count←load_val and load_err←0.
  - If any nibble is >9: count is unchanged and load_err←1.
  - en is ignored in a load cycle, so no count step occurs.
  - wrap←0.
- **Count up** (load=0, en=1, up=1):
  - Units +1. A digit at 9 goes to 0 and carries into the next digit; carries ripple through all digits in the same cycle.
  - At all-9s with sat=0: count←0, wrap←1.
  - At all-9s with sat=1: count holds, wrap←0.
- **Count down** (load=0, en=1, up=0):
  - Units −1. A digit at 0 goes to 9 and borrows from the next digit.
  - At all-0s with sat=0: count←all 9s, wrap←1.
  - At all-0s with sat=1: count holds, wrap←0.
- **Hold** (load=0, en=0): count unchanged, wrap←0, load_err←0.
- Within the same cycle, wrap and load_err are cleared in every cycle unless they are set as above. Neither ever stays high for two consecutive cycles unless the triggering event repeats.
- up and sat may change on any cycle. They take effect at the next edge and need no settling cycle.
- Count never holds a non-BCD nibble, because only validated loads and BCD arithmetic write the register.

## Timing
- Latency 1 clock from input (en/up/sat/load/load_val) to count; no pipeline.
- wrap and load_err assert in the same cycle that count shows the wrapped value, or the retained value for a rejected load.
- is_zero and is_max follow count combinationally, with zero added latency after the register.
- A reset in mid-count takes effect at the next edge. Any load or count step in that cycle is discarded.
- Full carry/borrow chain for DIGITS=8 must close timing in a single cycle. No multicycle paths.

## Test plan
- **Reset and step.** Hold rst_n=0 for 2 cycles with en=1 and load=1 → count=0, wrap=0, load_err=0, is_zero=1. Release; en=1, up=1 for 10 cycles → count=0x010.
- **Up wrap vs saturate.** Load 0x998, en=1, up=1, sat=0 → 0x999 (is_max=1), then 0x000 with wrap=1 for exactly one cycle. Repeat with sat=1 → count stays 0x999 and wrap stays 0.
- **Down borrow and wrap.** Load 0x100, up=0, en=1 → 0x099, then 0x098. Load 0x000, sat=0, one step → 0x999 with wrap=1. With sat=1 → count holds 0x000 and is_zero stays 1.
- **Load validation.** Load 0x123 → count=0x123, load_err=0. Load 0x1A3 → count stays 0x123 and load_err=1 for one cycle. Load 0xF00 → same rejection.
- **Simultaneous events.**
  - load=1 with en=1 and load_val=0x500 → count=0x500 with no step applied.
  - rst_n=0 with load=1 → count=0.
  - Toggle up every cycle from 0x050 → count alternates 0x051 and 0x050.
- **Parameter sweep.** Re-run the wrap and validation tests for DIGITS=1 (9→0 wrap, load 0xA rejected) and DIGITS=4 (0x9999→0x0000 wrap).

Source files
------------

// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter
//
// N-digit BCD up/down counter with validated parallel load and a selectable
// wrap/saturate behaviour at the range limits (0 and all nines).
//
// Parameters:
//   DIGITS    number of BCD digits, 1..8; range is 0 .. 10^DIGITS-1
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset (clears count, wrap, load_err)
//   en        count enable, one step per clock while high
//   up        direction: 1 = increment, 0 = decrement
//   sat       limit mode: 0 = wrap, 1 = saturate
//   load      parallel load request (wins over en)
//   load_val  load value, digit i in bits [4i+3:4i], digit 0 = units
//   count     registered BCD count, same packing as load_val
//   wrap      registered pulse, high the cycle after a wrap step
//   load_err  registered pulse, high the cycle after a rejected load
//   is_zero   combinational, count is all zeros
//   is_max    combinational, every digit of count is 9
module bcd_updown_counter #(
  parameter int unsigned DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                up,
  input  logic                sat,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic                wrap,
  output logic                load_err,
  output logic                is_zero,
  output logic                is_max
);

  localparam int unsigned W = 4 * DIGITS;

  if (DIGITS < 1 || DIGITS > 8) begin : gen_bad_digits
    $error("bcd_updown_counter: DIGITS must be in 1..8");
  end

  logic [W-1:0] count_q, count_d;
  logic         wrap_q, wrap_d;
  logic         load_err_q, load_err_d;

  logic [W-1:0] inc_val, dec_val, step_val;
  logic         load_ok;
  logic         all_zero, all_nine;
  logic         at_limit;
  logic         inc_carry, dec_borrow;

  // Per-digit classification of the load value and the current count.
  always_comb begin
    load_ok  = 1'b1;
    all_zero = 1'b1;
    all_nine = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) load_ok = 1'b0;
      if (count_q[4*i +: 4] != 4'd0) all_zero = 1'b0;
      if (count_q[4*i +: 4] != 4'd9) all_nine = 1'b0;
    end
  end

  // Ripple incrementer: each digit at 9 rolls to 0 and passes the carry on.
  // From all nines it naturally produces all zeros, i.e. the wrapped value.
  always_comb begin
    inc_val   = count_q;
    inc_carry = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (inc_carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          inc_carry         = 1'b0;
        end
      end
    end
  end

  // Ripple decrementer: each digit at 0 rolls to 9 and passes the borrow on.
  // From all zeros it naturally produces all nines, i.e. the wrapped value.
  always_comb begin
    dec_val    = count_q;
    dec_borrow = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (dec_borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          dec_borrow        = 1'b0;
        end
      end
    end
  end

  assign step_val = up ? inc_val : dec_val;
  assign at_limit = up ? all_nine : all_zero;

  // Next state: load beats count beats hold; pulses default low every cycle.
  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (load_ok) begin
        count_d = load_val;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (en) begin
      if (!at_limit) begin
        count_d = step_val;
      end else if (!sat) begin
        count_d = step_val;
        wrap_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;
  assign is_zero  = all_zero;
  assign is_max   = all_nine;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: three instances (DIGITS = 1, 3, 4) share one
// stimulus stream. A driver applies inputs and pushes the expected results of
// an integer-valued reference model into a queue; a monitor pops one entry per
// clock and compares it against all three instances.
module tb_bcd_updown_counter;

  logic        clk = 1'b0;
  logic        rst_n, en, up, sat, load;
  logic [31:0] load_val;

  logic [3:0]  cnt1;
  logic [11:0] cnt3;
  logic [15:0] cnt4;
  logic [2:0]  wrap_o, err_o, zero_o, max_o;

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIGITS(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .sat(sat), .load(load),
    .load_val(load_val[3:0]), .count(cnt1), .wrap(wrap_o[0]), .load_err(err_o[0]),
    .is_zero(zero_o[0]), .is_max(max_o[0])
  );

  bcd_updown_counter #(.DIGITS(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .sat(sat), .load(load),
    .load_val(load_val[11:0]), .count(cnt3), .wrap(wrap_o[1]), .load_err(err_o[1]),
    .is_zero(zero_o[1]), .is_max(max_o[1])
  );

  bcd_updown_counter #(.DIGITS(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .sat(sat), .load(load),
    .load_val(load_val[15:0]), .count(cnt4), .wrap(wrap_o[2]), .load_err(err_o[2]),
    .is_zero(zero_o[2]), .is_max(max_o[2])
  );

  typedef struct packed {
    logic [2:0][31:0] cnt;
    logic [2:0]       wr;
    logic [2:0]       er;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    digs[3] = '{1, 3, 4};
  int    mval[3];
  int    n_pass  = 0;
  int    n_total = 0;

  function automatic int pow10(input int d);
    int r = 1;
    for (int i = 0; i < d; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [31:0] to_bcd(input int v, input int d);
    logic [31:0] r = '0;
    int x = v;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Decimal value of the low d nibbles, or -1 if any of them is not a digit.
  function automatic int from_bcd(input logic [31:0] x, input int d);
    int v = 0;
    for (int i = d - 1; i >= 0; i--) begin
      logic [3:0] n;
      n = x[4*i +: 4];
      if (n > 4'd9) return -1;
      v = v * 10 + int'(n);
    end
    return v;
  endfunction

  function automatic void check(input string tag, input string what, input int k,
                                input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s %s (DIGITS=%0d): got 0x%0h, expected 0x%0h",
                  tag, what, digs[k], act, exp);
  endfunction

  task automatic drive(input bit r, input bit l, input bit e, input bit u, input bit s,
                       input logic [31:0] lv, input string tag);
    exp_t ex;
    @(negedge clk);
    rst_n = r; load = l; en = e; up = u; sat = s; load_val = lv;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      int mx, v;
      mx       = pow10(digs[k]) - 1;
      ex.wr[k] = 1'b0;
      ex.er[k] = 1'b0;
      if (!r) begin
        mval[k] = 0;
      end else if (l) begin
        v = from_bcd(lv, digs[k]);
        if (v < 0) ex.er[k] = 1'b1;
        else mval[k] = v;
      end else if (e) begin
        if (u) begin
          if (mval[k] < mx) mval[k] = mval[k] + 1;
          else if (!s) begin mval[k] = 0; ex.wr[k] = 1'b1; end
        end else begin
          if (mval[k] > 0) mval[k] = mval[k] - 1;
          else if (!s) begin mval[k] = mx; ex.wr[k] = 1'b1; end
        end
      end
      ex.cnt[k] = to_bcd(mval[k], digs[k]);
    end
    exp_q.push_back(ex);
    tag_q.push_back(tag);
  endtask

  // Monitor: one expected entry per clock, sampled 1 time unit after the edge.
  initial begin : monitor
    exp_t        ex;
    string       t;
    logic [31:0] act_cnt[3];
    logic [31:0] mx_bcd;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        t  = tag_q.pop_front();
        act_cnt[0] = {28'd0, cnt1};
        act_cnt[1] = {20'd0, cnt3};
        act_cnt[2] = {16'd0, cnt4};
        for (int k = 0; k < 3; k++) begin
          mx_bcd = to_bcd(pow10(digs[k]) - 1, digs[k]);
          check(t, "count", k, act_cnt[k], ex.cnt[k]);
          check(t, "wrap", k, {31'd0, wrap_o[k]}, {31'd0, ex.wr[k]});
          check(t, "load_err", k, {31'd0, err_o[k]}, {31'd0, ex.er[k]});
          check(t, "is_zero", k, {31'd0, zero_o[k]}, {31'd0, ex.cnt[k] == 32'd0});
          check(t, "is_max", k, {31'd0, max_o[k]}, {31'd0, ex.cnt[k] == mx_bcd});
        end
      end
    end
  end

  initial begin : stimulus
    logic [31:0] lv;
    bit          r, l, e, u, s;
    int          pick, idx;

    rst_n = 1'b0; en = 1'b0; up = 1'b1; sat = 1'b0; load = 1'b0; load_val = '0;
    mval  = '{0, 0, 0};

    // Reset overrides load and en.
    repeat (2) drive(0, 1, 1, 1, 0, 32'h0000_0555, "reset");
    repeat (10) drive(1, 0, 1, 1, 0, 32'h0, "step_up");

    // Up: wrap vs saturate.
    drive(1, 1, 0, 1, 0, 32'h0000_0998, "load_998");
    repeat (3) drive(1, 0, 1, 1, 0, 32'h0, "up_wrap");
    drive(1, 1, 0, 1, 1, 32'h0000_0998, "load_998s");
    repeat (3) drive(1, 0, 1, 1, 1, 32'h0, "up_sat");

    // Down: borrow, wrap, saturate.
    drive(1, 1, 0, 0, 0, 32'h0000_0100, "load_100");
    repeat (2) drive(1, 0, 1, 0, 0, 32'h0, "down_borrow");
    drive(1, 1, 0, 0, 0, 32'h0, "load_000");
    drive(1, 0, 1, 0, 0, 32'h0, "down_wrap");
    drive(1, 1, 0, 0, 1, 32'h0, "load_000s");
    repeat (2) drive(1, 0, 1, 0, 1, 32'h0, "down_sat");

    // Load validation.
    drive(1, 1, 0, 1, 0, 32'h0000_0123, "load_123");
    drive(1, 1, 0, 1, 0, 32'h0000_01A3, "load_1A3");
    drive(1, 0, 0, 1, 0, 32'h0, "hold");
    drive(1, 1, 0, 1, 0, 32'h0000_0F00, "load_F00");

    // Simultaneous events.
    drive(1, 1, 1, 1, 0, 32'h0000_0500, "load_en");
    drive(0, 1, 1, 1, 0, 32'h0000_0777, "reset_load");
    drive(1, 1, 0, 1, 0, 32'h0000_0050, "load_050");
    for (int i = 0; i < 6; i++) drive(1, 0, 1, (i % 2) == 0, 0, 32'h0, "toggle_up");

    // Width-specific limits: 0x9999 is max for DIGITS 1, 3 and 4 alike.
    drive(1, 1, 0, 1, 0, 32'h0000_9999, "load_9999");
    repeat (2) drive(1, 0, 1, 1, 0, 32'h0, "sweep_wrap");
    drive(1, 1, 0, 1, 0, 32'h0000_000A, "load_A");
    drive(1, 0, 1, 0, 0, 32'h0, "sweep_down");

    // Random traffic biased towards the limits.
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 49) != 0);
      l  = ($urandom_range(0, 7) == 0);
      e  = ($urandom_range(0, 3) != 0);
      u  = 1'($urandom_range(0, 1));
      s  = 1'($urandom_range(0, 1));
      lv = '0;
      for (int j = 0; j < 8; j++) begin
        pick = int'($urandom_range(0, 9));
        lv[4*j +: 4] = (pick < 4) ? 4'd9 : (pick < 7) ? 4'd0 : 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 9) == 0) begin
        idx = int'($urandom_range(0, 3));
        lv[4*idx +: 4] = 4'($urandom_range(10, 15));
      end
      drive(r, l, e, u, s, lv, "random");
    end

    // Drain the scoreboard, bounded.
    @(posedge clk);
    #2;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
